// File: rtl/camera_stream_gen_pkg.sv
// cam_gen_pkg: FSM states, pattern encodings, colour-bar table and CRC-16-CCITT helpers.
package cam_gen_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_e;
  typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_RAMP, PAT_COUNT} pattern_e;
  localparam logic [15:0] COLOR_BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? {c[14:0], 1'b0} ^ CRC_POLY : {c[14:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/camera_stream_gen_if.sv
// camera_stream_gen_if: DVP camera bus (pixel clock, frame/line syncs, byte data).
interface camera_stream_gen_if;
  logic camera_pclk;
  logic camera_vsync;
  logic camera_href;
  logic [7:0] camera_data;
  modport master(output camera_pclk, camera_vsync, camera_href, camera_data);
  modport slave(input camera_pclk, camera_vsync, camera_href, camera_data);
endinterface

// File: rtl/camera_stream_gen_pattern_rom.sv
// cam_pattern_rom: maps (pattern, pixel x, solid colour, frame count) to an RGB565 pixel.
module cam_pattern_rom import cam_gen_pkg::*; #(
  parameter int H_ACTIVE = 640,
  parameter int X_W = $clog2(H_ACTIVE)
) (
  input pattern_e sel,
  input logic [X_W-1:0] x,
  input logic [15:0] solid,
  input logic [15:0] fc,
  output logic [15:0] pix
);
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar;
  assign bar = 3'(x / X_W'(BAR_W));
  assign pix = sel == PAT_SOLID ? solid :
               sel == PAT_BARS  ? COLOR_BARS[bar] :
               sel == PAT_RAMP  ? 16'(x) : fc;
endmodule

// File: rtl/camera_stream_gen.sv
// camera_stream_gen: OV7670-style DVP test-pattern source; define STREAM_CRC_EN to add frame_crc (CRC-16-CCITT of each frame's href bytes).
module camera_stream_gen import cam_gen_pkg::*; #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK = 17,
  parameter int V_FRONT = 10,
  parameter int PCLK_DIV = 2
) (
  input logic clk_in_raw,
  input logic button_reset,
  input logic gen_enable,
  input logic [1:0] pattern_sel,
  input logic [15:0] solid_color,
  output logic frame_done,
  output logic [15:0] frame_count,
`ifdef STREAM_CRC_EN
  output logic [15:0] frame_crc,
`endif
  camera_stream_gen_if.master cam
);
  localparam int L = 2 * H_ACTIVE + H_BLANK;
  localparam int HALF = PCLK_DIV / 2;
  localparam int VM1 = VSYNC_LINES > V_BACK ? VSYNC_LINES : V_BACK;
  localparam int VM2 = V_ACTIVE > V_FRONT ? V_ACTIVE : V_FRONT;
  localparam int V_W = $clog2((VM1 > VM2 ? VM1 : VM2) + 1);
  localparam int H_W = $clog2(L);
  localparam int X_W = $clog2(H_ACTIVE);
  localparam int D_W = $clog2(PCLK_DIV);
  state_e state, state_n;
  pattern_e pat;
  logic [D_W-1:0] div, div_n;
  logic [H_W-1:0] hcnt, hcnt_n;
  logic [V_W-1:0] vcnt, vcnt_n;
  logic [15:0] solid, fc_lat, fc_n, pix;
  logic [7:0] data_n;
  logic tick, line_end, last, start, done, pclk_n, vsync_n, href_n;
  int lines;
  // All timing advances on the clk edge where pclk falls, so the bus is stable at each pclk rise.
  always_comb begin
    div_n = div == D_W'(PCLK_DIV - 1) ? '0 : div + 1'b1;
    tick = div == D_W'(HALF - 1);
    line_end = hcnt == H_W'(L - 1);
    lines = state == VSYNC ? VSYNC_LINES : state == VBACK ? V_BACK : state == ACTIVE ? V_ACTIVE : V_FRONT;
    last = line_end && int'(vcnt) == lines - 1;
    state_n = state;
    hcnt_n = hcnt;
    vcnt_n = vcnt;
    start = 1'b0;
    done = 1'b0;
    if (tick) begin
      hcnt_n = (state == IDLE || line_end) ? '0 : hcnt + 1'b1;
      vcnt_n = last ? '0 : line_end ? vcnt + 1'b1 : vcnt;
      case (state)
        IDLE: state_n = gen_enable ? VSYNC : IDLE;
        VSYNC: state_n = last ? VBACK : VSYNC;
        VBACK: state_n = last ? ACTIVE : VBACK;
        ACTIVE: state_n = last ? VFRONT : ACTIVE;
        default: state_n = last ? (gen_enable ? VSYNC : IDLE) : VFRONT;
      endcase
      done = state == VFRONT && last;
      start = state_n == VSYNC && state != VSYNC;
    end
    fc_n = frame_count + {15'd0, done};
    vsync_n = state_n == VSYNC;
    href_n = state_n == ACTIVE && int'(hcnt_n) < 2 * H_ACTIVE;
    pclk_n = state_n != IDLE && int'(div_n) < HALF;
  end
  cam_pattern_rom #(.H_ACTIVE(H_ACTIVE)) u_rom (
    .sel(pat), .x(X_W'(hcnt_n >> 1)), .solid(solid), .fc(fc_lat), .pix(pix)
  );
  assign data_n = href_n ? (hcnt_n[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  always_ff @(posedge clk_in_raw or negedge button_reset)
    if (!button_reset) begin
      state <= IDLE;
      pat <= PAT_SOLID;
      div <= '0;
      hcnt <= '0;
      vcnt <= '0;
      solid <= '0;
      fc_lat <= '0;
      frame_count <= '0;
      frame_done <= 1'b0;
      cam.camera_pclk <= 1'b0;
      cam.camera_vsync <= 1'b0;
      cam.camera_href <= 1'b0;
      cam.camera_data <= '0;
    end else begin
      state <= state_n;
      div <= div_n;
      hcnt <= hcnt_n;
      vcnt <= vcnt_n;
      frame_count <= fc_n;
      frame_done <= done;
      cam.camera_pclk <= pclk_n;
      cam.camera_vsync <= vsync_n;
      cam.camera_href <= href_n;
      cam.camera_data <= data_n;
      if (start) begin
        pat <= pattern_e'(pattern_sel);
        solid <= solid_color;
        fc_lat <= fc_n;
      end
    end
`ifdef STREAM_CRC_EN
  logic [15:0] crc_acc;
  always_ff @(posedge clk_in_raw or negedge button_reset)
    if (!button_reset) begin
      crc_acc <= CRC_INIT;
      frame_crc <= '0;
    end else if (done) begin
      crc_acc <= CRC_INIT;
      frame_crc <= crc_acc;
    end else if (tick && href_n) crc_acc <= crc16_byte(crc_acc, data_n);
`endif
endmodule

// File: tb/tb_camera_stream_gen.sv
// tb_camera_stream_gen: directed frames on a tiny 8x4 raster, checking timing, patterns, restart and async reset.
module tb_camera_stream_gen;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic clk = 1'b0;
  logic button_reset, gen_enable, frame_done;
  logic [1:0] pattern_sel;
  logic [15:0] solid_color, frame_count;
`ifdef STREAM_CRC_EN
  logic [15:0] frame_crc;
`endif
  camera_stream_gen_if cam();
  camera_stream_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .PCLK_DIV(2)
  ) dut (
    .clk_in_raw(clk), .button_reset(button_reset), .gen_enable(gen_enable),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .frame_done(frame_done), .frame_count(frame_count),
`ifdef STREAM_CRC_EN
    .frame_crc(frame_crc),
`endif
    .cam(cam)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  int pclk_cnt, vs_cnt, first_vs, first_href, stab_err = 0, zero_err = 0;
  logic [7:0] bytes[$];
  int idx[$];
  time last_chg = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_mon();
    bytes.delete();
    idx.delete();
    pclk_cnt = 0;
    vs_cnt = 0;
    first_vs = 0;
    first_href = -1;
  endtask
  function automatic logic [7:0] exp_byte(input int pat, input logic [15:0] solid, input logic [15:0] fc, input int k);
    logic [15:0] p;
    p = pat == 0 ? solid : pat == 1 ? BARS[k / 2] : pat == 2 ? 16'(k / 2) : fc;
    return k % 2 == 0 ? p[15:8] : p[7:0];
  endfunction
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    c ^= {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction
  always @(cam.camera_vsync or cam.camera_href or cam.camera_data) last_chg = $time;
  always @(posedge cam.camera_pclk) begin
    time t_rise;
    t_rise = $time;
    #1;
    if (last_chg == t_rise) stab_err++;
    if (pclk_cnt == 0) first_vs = int'(cam.camera_vsync);
    if (cam.camera_vsync) vs_cnt++;
    if (cam.camera_href) begin
      if (first_href < 0) first_href = pclk_cnt;
      bytes.push_back(cam.camera_data);
      idx.push_back(pclk_cnt);
    end else if (cam.camera_data != 8'h00) zero_err++;
    pclk_cnt++;
  end
  task automatic run_frame(input string tag, input int pat, input logic [15:0] solid,
                           input logic [15:0] fc_lat, input int nxt, input bit drop, input logic [15:0] fc_exp);
    logic [7:0] q[$];
    int iq[$];
    int pc, vc, fv, fh, bad, badpos;
    bit seen;
    logic [15:0] fc_got, crc, crc_got;
    @(negedge clk);
    pattern_sel = 2'(pat);
    solid_color = solid;
    gen_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (bytes.size() >= 20) begin
        pattern_sel = 2'(nxt);
        if (drop) gen_enable = 1'b0;
      end
      seen = frame_done;
    end
    q = bytes;
    iq = idx;
    pc = pclk_cnt;
    vc = vs_cnt;
    fv = first_vs;
    fh = first_href;
    fc_got = frame_count;
    crc_got = 16'h0;
`ifdef STREAM_CRC_EN
    crc_got = frame_crc;
`endif
    clear_mon();
    chk({tag, "_done_seen"}, seen, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, frame_done, 0);
    chk({tag, "_pclk_periods"}, pc, 140);
    chk({tag, "_vsync_periods"}, vc, 20);
    chk({tag, "_first_vsync"}, fv, 1);
    chk({tag, "_first_href"}, fh, 40);
    chk({tag, "_byte_count"}, q.size(), 64);
    chk({tag, "_count"}, fc_got, fc_exp);
    bad = 0;
    badpos = 0;
    crc = 16'hFFFF;
    for (int k = 0; k < 64; k++) begin
      crc = crc_step(crc, exp_byte(pat, solid, fc_lat, k % 16));
      if (k < q.size() && q[k] !== exp_byte(pat, solid, fc_lat, k % 16)) bad++;
      if (k < iq.size() && iq[k] != 40 + 20 * (k / 16) + k % 16) badpos++;
    end
    chk({tag, "_byte_values"}, bad, 0);
    chk({tag, "_byte_positions"}, badpos, 0);
    if (q.size() > 3) chk({tag, "_byte3"}, q[3], exp_byte(pat, solid, fc_lat, 3));
`ifdef STREAM_CRC_EN
    chk({tag, "_crc"}, crc_got, crc);
`else
    chk({tag, "_crc_model_nonzero"}, crc == 16'h0, 0);
`endif
  endtask
  initial begin
    bit seen;
    button_reset = 1'b0;
    gen_enable = 1'b0;
    pattern_sel = 2'd0;
    solid_color = 16'h0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cam.camera_pclk, cam.camera_vsync, cam.camera_href, cam.camera_data, frame_done, frame_count}, 0);
`ifdef STREAM_CRC_EN
    chk("reset_crc", frame_crc, 0);
`endif
    button_reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_pclk_before", cam.camera_pclk, 0);
    run_frame("f1_solid", 0, 16'hAAAA, 16'h0, 1, 1'b0, 16'd1);
    run_frame("f2_bars", 1, 16'h0, 16'h1, 1, 1'b1, 16'd2);
    clear_mon();
    repeat (50) @(negedge clk);
    chk("idle_pclk_rises", pclk_cnt, 0);
    chk("idle_pclk_low", cam.camera_pclk, 0);
    chk("idle_count_held", frame_count, 2);
    run_frame("f3_count", 3, 16'h0, 16'h2, 2, 1'b0, 16'd3);
    run_frame("f4_ramp", 2, 16'h0, 16'h3, 2, 1'b1, 16'd4);
    @(negedge clk);
    pattern_sel = 2'd0;
    solid_color = 16'h1234;
    gen_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = cam.camera_href;
    end
    chk("rst_wait_href", seen, 1);
    #2 button_reset = 1'b0;
    gen_enable = 1'b0;
    #1 chk("rst_async_outputs", {cam.camera_pclk, cam.camera_vsync, cam.camera_href, cam.camera_data, frame_done, frame_count}, 0);
    @(negedge clk);
    button_reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_pclk", cam.camera_pclk, 0);
    chk("post_rst_count", frame_count, 0);
    clear_mon();
    run_frame("f6_restart", 0, 16'h5A3C, 16'h0, 0, 1'b1, 16'd1);
    chk("bus_stable_at_pclk_rise", stab_err, 0);
    chk("data_zero_without_href", zero_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
